// File: rtl/crc_sched.sv
`default_nettype none
// ============================================================================
// crc_sched : two-requester round-robin front end for a shared CRC engine
// Rev 1.0
// ============================================================================
module crc_sched #(
  parameter int DATA_INP_WD = 8,
  parameter int DATA_OUT_WD = 32,
  parameter int LEN_WD      = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req0_val_i,
  input  logic                   req0_lst_i,
  input  logic [DATA_INP_WD-1:0] req0_dat_i,
  output logic                   req0_rdy_o,
  input  logic                   req1_val_i,
  input  logic                   req1_lst_i,
  input  logic [DATA_INP_WD-1:0] req1_dat_i,
  output logic                   req1_rdy_o,
  output logic                   eng_val_o,
  output logic                   eng_flg_fst_o,
  output logic                   eng_flg_lst_o,
  output logic [DATA_INP_WD-1:0] eng_dat_o,
  output logic                   eng_sid_o,
  input  logic                   eng_val_i,
  input  logic [DATA_OUT_WD-1:0] eng_dat_i,
  output logic                   res_val_o,
  input  logic                   res_rdy_i,
  output logic                   res_id_o,
  output logic [DATA_OUT_WD-1:0] res_dat_o,
  output logic [LEN_WD-1:0]      res_len_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [LEN_WD-1:0] c_cnt_max = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ptr;
  logic                   r_own;
  logic [LEN_WD-1:0]      r_cnt;
  logic                   r_res_val;
  logic                   r_res_id;
  logic [DATA_OUT_WD-1:0] r_res_dat;
  logic [LEN_WD-1:0]      r_res_len;
  logic                   r_err;

  logic                   w_win;
  logic                   w_grant;
  logic                   w_sel;
  logic                   w_sel_val;
  logic                   w_sel_lst;
  logic [DATA_INP_WD-1:0] w_sel_dat;
  logic                   w_acc;

  // Contention goes to whoever was not granted last; a lone requester wins outright.
  assign w_win     = (req0_val_i & req1_val_i) ? ~r_ptr : req1_val_i;
  assign w_grant   = (r_state == S_IDLE) & ~r_res_val & (req0_val_i | req1_val_i);
  assign w_sel     = (r_state == S_IDLE) ? w_win : r_own;
  assign w_sel_val = w_sel ? req1_val_i : req0_val_i;
  assign w_sel_lst = w_sel ? req1_lst_i : req0_lst_i;
  assign w_sel_dat = w_sel ? req1_dat_i : req0_dat_i;

  always_comb begin
    w_state_nxt   = r_state;
    req0_rdy_o    = 1'b0;
    req1_rdy_o    = 1'b0;
    eng_val_o     = 1'b0;
    eng_flg_fst_o = 1'b0;
    eng_flg_lst_o = 1'b0;
    eng_dat_o     = '0;
    eng_sid_o     = 1'b0;
    w_acc         = 1'b0;
    // Combinational outputs are gated so everything reads zero while reset is held.
    if (rstn) begin
      eng_sid_o = r_own;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            req0_rdy_o    = ~w_sel;
            req1_rdy_o    = w_sel;
            eng_val_o     = 1'b1;
            eng_flg_fst_o = 1'b1;
            eng_flg_lst_o = w_sel_lst;
            eng_dat_o     = w_sel_dat;
            eng_sid_o     = w_sel;
            w_acc         = 1'b1;
            w_state_nxt   = w_sel_lst ? S_WAIT : S_BUSY;
          end
        end
        S_BUSY: begin
          req0_rdy_o    = ~w_sel;
          req1_rdy_o    = w_sel;
          eng_val_o     = w_sel_val;
          eng_flg_lst_o = w_sel_lst;
          eng_dat_o     = w_sel_dat;
          w_acc         = w_sel_val;
          if (w_sel_val && w_sel_lst) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b1;
      r_own     <= 1'b0;
      r_cnt     <= '0;
      r_res_val <= 1'b0;
      r_res_id  <= 1'b0;
      r_res_dat <= '0;
      r_res_len <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= w_win;
        r_own <= w_win;
        r_cnt <= LEN_WD'(1);
      end else if (w_acc && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A result can only land in WAIT, which is unreachable while one is pending.
      if ((r_state == S_WAIT) && eng_val_i) begin
        r_res_val <= 1'b1;
        r_res_id  <= r_own;
        r_res_dat <= eng_dat_i;
        r_res_len <= r_cnt;
      end else if (r_res_val && res_rdy_i) begin
        r_res_val <= 1'b0;
      end
      // Engine strobe outside WAIT, or a missing strobe in WAIT, is a protocol error.
      if (eng_val_i != (r_state == S_WAIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign res_val_o = r_res_val;
  assign res_id_o  = r_res_id;
  assign res_dat_o = r_res_dat;
  assign res_len_o = r_res_len;
  assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_crc_sched.sv
`default_nettype none
// Testbench for crc_sched: random requesters and a CRC-32 engine model,
// checked against a frame-level reference of arbitration and results.
module tb_crc_sched;

  logic        clk;
  logic        rstn;
  logic        req0_val_i, req0_lst_i, req0_rdy_o;
  logic [7:0]  req0_dat_i;
  logic        req1_val_i, req1_lst_i, req1_rdy_o;
  logic [7:0]  req1_dat_i;
  logic        eng_val_o, eng_flg_fst_o, eng_flg_lst_o, eng_sid_o;
  logic [7:0]  eng_dat_o;
  logic        eng_val_i;
  logic [31:0] eng_dat_i;
  logic        res_val_o, res_rdy_i, res_id_o, err_o;
  logic [31:0] res_dat_o;
  logic [15:0] res_len_o;

  crc_sched dut (
    .clk(clk), .rstn(rstn),
    .req0_val_i(req0_val_i), .req0_lst_i(req0_lst_i), .req0_dat_i(req0_dat_i), .req0_rdy_o(req0_rdy_o),
    .req1_val_i(req1_val_i), .req1_lst_i(req1_lst_i), .req1_dat_i(req1_dat_i), .req1_rdy_o(req1_rdy_o),
    .eng_val_o(eng_val_o), .eng_flg_fst_o(eng_flg_fst_o), .eng_flg_lst_o(eng_flg_lst_o),
    .eng_dat_o(eng_dat_o), .eng_sid_o(eng_sid_o),
    .eng_val_i(eng_val_i), .eng_dat_i(eng_dat_i),
    .res_val_o(res_val_o), .res_rdy_i(res_rdy_i), .res_id_o(res_id_o),
    .res_dat_o(res_dat_o), .res_len_o(res_len_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int p_val = 100;
  int p_rdy = 100;
  int n_res = 0;
  int grants[$];

  // requester byte queues
  logic [7:0] q_dat[2][$];
  logic       q_lst[2][$];

  // frame-level reference state
  logic        m_busy, m_wait, m_own, m_ptr;
  logic [15:0] m_cnt;
  logic [31:0] m_crc;
  logic        x_val, x_id, x_err;
  logic [15:0] x_len;
  logic [31:0] x_dat;

  // engine model state
  logic        eng_fire, inj_now, sup_wait;
  logic [31:0] eng_res, e_crc;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_own = 0; m_ptr = 1; m_cnt = 0; m_crc = 0;
    x_val = 0; x_id = 0; x_len = 0; x_dat = 0; x_err = 0;
    eng_fire = 0; inj_now = 0; sup_wait = 0; eng_res = 0; e_crc = 0;
    for (int r = 0; r < 2; r++) begin
      q_dat[r].delete();
      q_lst[r].delete();
    end
  endtask

  task automatic push_frame(input int r, input int len);
    for (int i = 0; i < len; i++) begin
      q_dat[r].push_back(8'($urandom));
      q_lst[r].push_back(i == len - 1);
    end
  endtask

  task automatic cycle();
    logic       v[2];
    logic       l[2];
    logic [7:0] d[2];
    logic [1:0] e_rdy;
    logic       e_acc, e_win;
    int         e_src;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      if (q_dat[r].size() > 0 && $urandom_range(99) < p_val) begin
        v[r] = 1'b1; d[r] = q_dat[r][0]; l[r] = q_lst[r][0];
      end else begin
        v[r] = 1'b0; d[r] = 8'($urandom); l[r] = 1'($urandom);
      end
    end
    req0_val_i = v[0]; req0_dat_i = d[0]; req0_lst_i = l[0];
    req1_val_i = v[1]; req1_dat_i = d[1]; req1_lst_i = l[1];
    res_rdy_i  = ($urandom_range(99) < p_rdy);
    eng_val_i  = (eng_fire && !sup_wait) || inj_now;
    eng_dat_i  = eng_res;
    #1;
    e_rdy = 2'b00;
    if (m_busy) e_rdy[m_own] = 1'b1;
    else if (!m_wait && !x_val && (v[0] || v[1])) begin
      e_win = (v[0] && v[1]) ? ~m_ptr : v[1];
      e_rdy[e_win] = 1'b1;
    end
    e_src = e_rdy[1] ? 1 : 0;
    e_acc = (e_rdy[0] && v[0]) || (e_rdy[1] && v[1]);

    vecs++;
    if ({req1_rdy_o, req0_rdy_o} !== e_rdy) begin
      errs++; $display("FAIL rdy t=%0t got %b exp %b", $time, {req1_rdy_o, req0_rdy_o}, e_rdy);
    end
    vecs++;
    if (eng_val_o !== e_acc) begin
      errs++; $display("FAIL eng_val t=%0t got %b exp %b", $time, eng_val_o, e_acc);
    end
    if (e_acc) begin
      vecs++;
      if ({eng_dat_o, eng_flg_fst_o, eng_flg_lst_o, eng_sid_o} !== {d[e_src], !m_busy, l[e_src], 1'(e_src)}) begin
        errs++;
        $display("FAIL eng_byte t=%0t got dat=%h fst=%b lst=%b sid=%b exp dat=%h fst=%b lst=%b sid=%0d",
                 $time, eng_dat_o, eng_flg_fst_o, eng_flg_lst_o, eng_sid_o, d[e_src], !m_busy, l[e_src], e_src);
      end
    end
    vecs++;
    if (res_val_o !== x_val) begin
      errs++; $display("FAIL res_val t=%0t got %b exp %b", $time, res_val_o, x_val);
    end
    if (x_val) begin
      vecs++;
      if ({res_id_o, res_len_o, res_dat_o} !== {x_id, x_len, x_dat}) begin
        errs++;
        $display("FAIL res t=%0t got id=%b len=%0d dat=%h exp id=%b len=%0d dat=%h",
                 $time, res_id_o, res_len_o, res_dat_o, x_id, x_len, x_dat);
      end
    end
    vecs++;
    if (err_o !== x_err) begin
      errs++; $display("FAIL err t=%0t got %b exp %b", $time, err_o, x_err);
    end
    if (eng_val_o === 1'b1 && eng_flg_fst_o === 1'b1) grants.push_back(int'(eng_sid_o));

    // advance the reference to the next cycle
    if (eng_val_i != m_wait) x_err = 1'b1;
    if (x_val && res_rdy_i) begin x_val = 1'b0; n_res++; end
    if (m_wait && eng_val_i) begin
      x_val = 1'b1; x_id = m_own; x_len = m_cnt; x_dat = ~m_crc;
    end
    m_wait = 1'b0;
    if (e_acc) begin
      if (!m_busy) begin
        m_own = 1'(e_src); m_ptr = 1'(e_src); m_cnt = 16'd1; m_crc = crc_upd(32'hFFFFFFFF, d[e_src]);
      end else begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_crc = crc_upd(m_crc, d[e_src]);
      end
      m_busy = !l[e_src];
      m_wait = l[e_src];
      void'(q_dat[e_src].pop_front());
      void'(q_lst[e_src].pop_front());
    end
    eng_fire = 1'b0;
    if (eng_val_o === 1'b1) begin
      e_crc = crc_upd(eng_flg_fst_o ? 32'hFFFFFFFF : e_crc, eng_dat_o);
      if (eng_flg_lst_o) begin eng_fire = 1'b1; eng_res = ~e_crc; end
    end
    inj_now = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((q_dat[0].size() > 0 || q_dat[1].size() > 0 || m_busy || m_wait || x_val) && n < budget) begin
      cycle();
      n++;
    end
    vecs++;
    if (n >= budget) begin
      errs++; $display("FAIL %s drain: used %0d cycles, limit %0d", tag, n, budget);
    end
  endtask

  task automatic do_reset();
    logic [64:0] all_o;
    @(negedge clk);
    req0_val_i = 1'b1; req1_val_i = 1'b1; res_rdy_i = 1'b0; eng_val_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    all_o = {req0_rdy_o, req1_rdy_o, eng_val_o, eng_flg_fst_o, eng_flg_lst_o, eng_dat_o, eng_sid_o,
             res_val_o, res_id_o, res_dat_o, res_len_o, err_o};
    vecs++;
    if (all_o !== 65'd0) begin
      errs++; $display("FAIL reset_outputs t=%0t got %h exp 0", $time, all_o);
    end
    model_reset();
    repeat (2) @(negedge clk);
    req0_val_i = 1'b0; req1_val_i = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_crc_vector();
    for (int i = 0; i < 9; i++) begin
      q_dat[0].push_back(8'h31 + 8'(i));
      q_lst[0].push_back(i == 8);
    end
    p_val = 100; p_rdy = 0;
    run_n(12);
    vecs++;
    if ({res_val_o, res_id_o, res_len_o, res_dat_o} !== {1'b1, 1'b0, 16'd9, 32'hCBF43926}) begin
      errs++;
      $display("FAIL crc_check got val=%b id=%b len=%0d dat=%h exp val=1 id=0 len=9 dat=cbf43926",
               res_val_o, res_id_o, res_len_o, res_dat_o);
    end
    p_rdy = 100;
    run_drain(50, "crc");
  endtask

  task automatic test_single_and_hold();
    logic [31:0] held;
    q_dat[1].push_back(8'h5A); q_lst[1].push_back(1'b1);
    p_val = 100; p_rdy = 0;
    run_n(4);
    vecs++;
    if ({res_val_o, res_id_o, res_len_o} !== {1'b1, 1'b1, 16'd1}) begin
      errs++; $display("FAIL single got val=%b id=%b len=%0d exp val=1 id=1 len=1", res_val_o, res_id_o, res_len_o);
    end
    held = x_dat;
    push_frame(1, 2);
    run_n(6);
    vecs++;
    if (res_dat_o !== held) begin
      errs++; $display("FAIL hold_dat got %h exp %h", res_dat_o, held);
    end
    p_rdy = 100;
    run_drain(50, "hold");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      push_frame(0, 2);
      push_frame(1, 2);
    end
    p_val = 100; p_rdy = 100;
    grants.delete();
    run_drain(200, "b2b");
    vecs++;
    if (grants.size() != 8) begin
      errs++; $display("FAIL b2b_count got %0d exp 8", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      vecs++;
      if (grants[i] != (i % 2)) begin
        errs++; $display("FAIL b2b_order idx=%0d got %0d exp %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    push_frame(0, 4);
    p_val = 100; p_rdy = 100;
    cycle();
    inj_now = 1'b1;
    cycle();
    run_drain(50, "err_busy");
    vecs++;
    if (err_o !== 1'b1) begin
      errs++; $display("FAIL err_busy got %b exp 1", err_o);
    end
    do_reset();
    push_frame(1, 2);
    sup_wait = 1'b1;
    run_drain(50, "err_wait");
    sup_wait = 1'b0;
    run_n(3);
    vecs++;
    if (err_o !== 1'b1) begin
      errs++; $display("FAIL err_wait got %b exp 1", err_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(1, 6);
    p_val = 100; p_rdy = 100;
    run_n(2);
    do_reset();
    grants.delete();
    push_frame(0, 1);
    push_frame(1, 1);
    cycle();
    vecs++;
    if (grants.size() != 1 || grants[0] != 0) begin
      errs++; $display("FAIL reset_mid_grant got n=%0d first=%0d exp n=1 first=0",
                       grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
    run_drain(50, "reset_mid");
  endtask

  task automatic test_random();
    int base;
    do_reset();
    for (int f = 0; f < 40; f++) push_frame($urandom_range(1), $urandom_range(6, 1));
    p_val = 70; p_rdy = 60;
    base = n_res;
    run_drain(5000, "random");
    vecs++;
    if (n_res - base != 40) begin
      errs++; $display("FAIL random_results got %0d exp 40", n_res - base);
    end
  endtask

  initial begin
    rstn = 1'b1;
    req0_val_i = 0; req0_lst_i = 0; req0_dat_i = 0;
    req1_val_i = 0; req1_lst_i = 0; req1_dat_i = 0;
    res_rdy_i = 0; eng_val_i = 0; eng_dat_i = 0;
    model_reset();
    test_reset();
    test_crc_vector();
    test_single_and_hold();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
